top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-high; ports are named clk and sys_rst.
REQ-002 SHALL expose ports (clock and reset first):
- clk      input   1   system clock; all state updates on the rising edge
- sys_rst  input   1   asynchronous, active-high reset
- din      input   16  reserved data input; ignored by every opcode
- dout     output  16  registered copy of the last value written to a GPR
REQ-003 SHALL contain internal state reachable by hierarchical reference:
- IR: 32-bit instruction register
- GPR[0..31]: 16-bit registers
- SGPR: 16-bit special register
REQ-004 SHALL decode IR fields as follows:
- oper_type = IR[31:27]
- rdst = IR[26:22]
- rsrc1 = IR[21:17]
- imm_mode = IR[16]
- rsrc2 = IR[15:11]
- isrc = IR[15:0]

Function
REQ-005 SHALL execute the instruction held in IR on every rising clk edge while sys_rst is low, and write the result to GPR[rdst] at that edge (1-cycle latency).
REQ-006 SHALL use operand A = GPR[rsrc1].
REQ-007 SHALL use operand B = isrc when imm_mode is 1, and GPR[rsrc2] when imm_mode is 0.
REQ-008 SHALL implement these opcodes:
- 0 movsgpr: GPR[rdst] = SGPR
- 1 mov: GPR[rdst] = B when imm_mode is 1, else GPR[rsrc1]
- 2 add: GPR[rdst] = A + B (16-bit wrap, carry discarded)
- 3 sub: GPR[rdst] = A - B (16-bit wrap)
- 4 mul: 32-bit product of A and B (unsigned); GPR[rdst] = product[15:0], SGPR = product[31:16], both at the same edge
- 5 or, 6 and, 7 xor, 8 xnor, 9 nand, 10 nor: bitwise A op B, 16 bits
- 11 not: GPR[rdst] = ~A; rsrc2, isrc and imm_mode are ignored
REQ-009 SHALL treat opcodes 12-31 as no-ops: no GPR, SGPR or dout change.
REQ-010 SHALL modify SGPR only on opcode 4; it holds its value otherwise.
REQ-011 SHALL read all operands from pre-edge register values, so that rdst equal to rsrc1 or rsrc2 uses the old value.
REQ-012 SHALL update dout with the same value written to GPR[rdst] on the same edge, and hold it on no-ops.
REQ-013 SHALL treat all arithmetic as unsigned; overflow wraps with no flags.
REQ-014 SHALL NOT modify IR by any opcode; IR is written only by reset or by external (hierarchical) load.

Reset
REQ-015 SHALL, while sys_rst is high, asynchronously clear IR, all 32 GPRs, SGPR and dout to 0, regardless of clk.
REQ-016 SHALL, when sys_rst asserts mid-operation, discard any in-flight result; execution resumes at the first rising edge after deassertion.

Verification
REQ-017 Preset all GPRs to 2; IR is add, imm_mode 1, rsrc1 2, rdst 0, isrc 4; one edge -> GPR[0] = 6 and dout = 6.
REQ-018 Register add GPR[4] + GPR[5] into GPR[0] -> 4; then mov imm 55 into GPR[4] -> 55; then register mov GPR[7] into GPR[4] -> 2.
REQ-019 mul imm: GPR[2] = 2, isrc 4, rdst 0 -> GPR[0] = 8, SGPR = 0; then mul GPR[0] × GPR[1] into GPR[2] -> 16; then movsgpr into GPR[3] -> 0; also 16'hFFFF × 16'hFFFF -> low 16'h0001, SGPR = 16'hFFFE.
REQ-020 Logic sequence:
- andi GPR[7] = 2 with 56 -> GPR[4] = 0
- xori -> GPR[4] = 58
- or GPR[4] | GPR[16] -> GPR[0] = 58
- nor -> 16'hFFC5
- not GPR[6] -> 16'hFFFD
REQ-021 Assert sys_rst asynchronously between edges mid-sequence -> all GPRs, SGPR, IR and dout read 0 immediately; opcode 15 after release -> no state change.
REQ-022 Boundaries:
- add 16'hFFFF + 1 -> 0
- sub 0 - 1 -> 16'hFFFF
- rdst = rsrc1 = 5 with add of 1 on GPR[5] = 2 -> 3 after one edge, 4 after a second edge

Source files
------------

// File: rtl/top.sv
// Single-cycle 16-bit register-file datapath: executes the instruction held in IR
// on every rising clock edge and writes the result into the GPR file, SGPR and dout.
module top (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic [15:0] din,
    output logic [15:0] dout
);

    typedef enum logic [4:0] {
        OP_MOVSGPR = 5'd0,
        OP_MOV     = 5'd1,
        OP_ADD     = 5'd2,
        OP_SUB     = 5'd3,
        OP_MUL     = 5'd4,
        OP_OR      = 5'd5,
        OP_AND     = 5'd6,
        OP_XOR     = 5'd7,
        OP_XNOR    = 5'd8,
        OP_NAND    = 5'd9,
        OP_NOR     = 5'd10,
        OP_NOT     = 5'd11
    } opcode_e;

    // IR, GPR and SGPR keep these exact names so they can be reached hierarchically.
    logic [31:0] IR;
    logic [15:0] GPR [0:31];
    logic [15:0] SGPR;

    logic [4:0]  oper_type;
    logic [4:0]  rdst;
    logic [4:0]  rsrc1;
    logic        imm_mode;
    logic [4:0]  rsrc2;
    logic [15:0] isrc;

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] prod;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        sgpr_we;

    // din is a reserved input that no opcode consumes.
    logic        unused_din;
    assign unused_din = ^din;

    assign oper_type = IR[31:27];
    assign rdst      = IR[26:22];
    assign rsrc1     = IR[21:17];
    assign imm_mode  = IR[16];
    assign rsrc2     = IR[15:11];
    assign isrc      = IR[15:0];

    always_comb begin
        op_a    = GPR[rsrc1];
        op_b    = imm_mode ? isrc : GPR[rsrc2];
        prod    = {16'd0, op_a} * {16'd0, op_b};
        wr_data = '0;
        wr_en   = 1'b1;
        sgpr_we = 1'b0;
        case (oper_type)
            OP_MOVSGPR: wr_data = SGPR;
            OP_MOV:     wr_data = imm_mode ? op_b : op_a;
            OP_ADD:     wr_data = op_a + op_b;
            OP_SUB:     wr_data = op_a - op_b;
            OP_MUL: begin
                wr_data = prod[15:0];
                sgpr_we = 1'b1;
            end
            OP_OR:      wr_data = op_a | op_b;
            OP_AND:     wr_data = op_a & op_b;
            OP_XOR:     wr_data = op_a ^ op_b;
            OP_XNOR:    wr_data = ~(op_a ^ op_b);
            OP_NAND:    wr_data = ~(op_a & op_b);
            OP_NOR:     wr_data = ~(op_a | op_b);
            OP_NOT:     wr_data = ~op_a;
            default:    wr_en   = 1'b0;
        endcase
    end

    // IR has no functional write path: it only clears on reset and otherwise holds,
    // leaving instruction loading to the environment.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            IR   <= '0;
            SGPR <= '0;
            dout <= '0;
            for (int i = 0; i < 32; i++) begin
                GPR[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                GPR[rdst] <= wr_data;
                dout      <= wr_data;
            end
            if (sgpr_we) begin
                SGPR <= prod[31:16];
            end
        end
    end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: instructions are loaded into IR hierarchically, a
// reference model pushes expected write-back values into a queue, and the DUT is checked.
module tb_top;

  logic        clk;
  logic        sys_rst;
  logic [15:0] din;
  logic [15:0] dout;

  int checks;
  int errors;
  logic [15:0] exp_q[$];

  logic [15:0] m_gpr [0:31];
  logic [15:0] m_sgpr;
  logic [15:0] m_dout;

  top dut (
    .clk    (clk),
    .sys_rst(sys_rst),
    .din    (din),
    .dout   (dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] r1, input logic [15:0] imm);
    enc_i = {op, rd, r1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] r1, input logic [4:0] r2);
    enc_r = {op, rd, r1, 1'b0, r2, 11'd0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_sgpr = '0;
    m_dout = '0;
    exp_q.delete();
  endtask

  task automatic preset(input logic [15:0] val);
    for (int i = 0; i < 32; i++) begin
      dut.GPR[i] = val;
      m_gpr[i]   = val;
    end
  endtask

  // driver: called at posedge+1; loads IR, runs the model, steps one edge
  task automatic drive_instr(input logic [31:0] instr, output bit wr);
    logic [4:0]  op, rd, r1, r2;
    logic        im;
    logic [15:0] a, b, res;
    logic [31:0] p;
    op = instr[31:27]; rd = instr[26:22]; r1 = instr[21:17];
    im = instr[16];    r2 = instr[15:11];
    a  = m_gpr[r1];
    b  = im ? instr[15:0] : m_gpr[r2];
    p  = 32'(a) * 32'(b);
    wr = 1'b1;
    res = '0;
    case (op)
      5'd0:  res = m_sgpr;
      5'd1:  res = im ? b : a;
      5'd2:  res = a + b;
      5'd3:  res = a - b;
      5'd4:  begin res = p[15:0]; m_sgpr = p[31:16]; end
      5'd5:  res = a | b;
      5'd6:  res = a & b;
      5'd7:  res = a ^ b;
      5'd8:  res = ~(a ^ b);
      5'd9:  res = ~(a & b);
      5'd10: res = ~(a | b);
      5'd11: res = ~a;
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_gpr[rd] = res;
      m_dout    = res;
      exp_q.push_back(res);
    end
    dut.IR = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut.IR !== 32'd0) begin errors++; $display("FAIL reset_ir: got %h expected 0", dut.IR); end
    checks++;
    if (dout !== 16'd0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    checks++;
    if (dut.SGPR !== 16'd0) begin errors++; $display("FAIL reset_sgpr: got %h expected 0", dut.SGPR); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.GPR[i] !== 16'd0) begin
        errors++; $display("FAIL reset_gpr%0d: got %h expected 0", i, dut.GPR[i]);
      end
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_add_imm();
    bit wr;
    logic [15:0] e;
    preset(16'd2);
    drive_instr(enc_i(5'd2, 5'd0, 5'd2, 16'd4), wr);
    e = exp_q.pop_front();
    checks++;
    if (dut.GPR[0] !== e) begin errors++; $display("FAIL add_imm_gpr: got %h expected %h", dut.GPR[0], e); end
    checks++;
    if (dout !== 16'd6) begin errors++; $display("FAIL add_imm_dout: got %h expected 0006", dout); end
    checks++;
    if (dut.IR !== enc_i(5'd2, 5'd0, 5'd2, 16'd4)) begin
      errors++; $display("FAIL ir_held: got %h expected %h", dut.IR, enc_i(5'd2, 5'd0, 5'd2, 16'd4));
    end
  endtask

  task automatic test_mov();
    bit wr;
    logic [15:0] e;
    logic [31:0] prog [3];
    logic [4:0]  dst  [3];
    logic [15:0] lit  [3];
    prog[0] = enc_r(5'd2, 5'd0, 5'd4, 5'd5);  dst[0] = 5'd0; lit[0] = 16'd4;
    prog[1] = enc_i(5'd1, 5'd4, 5'd0, 16'd55); dst[1] = 5'd4; lit[1] = 16'd55;
    prog[2] = enc_r(5'd1, 5'd4, 5'd7, 5'd0);  dst[2] = 5'd4; lit[2] = 16'd2;
    preset(16'd2);
    for (int i = 0; i < 3; i++) begin
      drive_instr(prog[i], wr);
      e = exp_q.pop_front();
      checks++;
      if (dut.GPR[dst[i]] !== e) begin
        errors++; $display("FAIL mov_step%0d_gpr: got %h expected %h", i, dut.GPR[dst[i]], e);
      end
      checks++;
      if (dout !== lit[i]) begin
        errors++; $display("FAIL mov_step%0d_dout: got %h expected %h", i, dout, lit[i]);
      end
    end
  endtask

  task automatic test_mul();
    bit wr;
    logic [15:0] e;
    logic [31:0] prog [6];
    logic [4:0]  dst  [6];
    logic [15:0] lit  [6];
    logic [15:0] sg   [6];
    prog[0] = enc_i(5'd4, 5'd0, 5'd2, 16'd4);      dst[0] = 5'd0;  lit[0] = 16'd8;      sg[0] = 16'd0;
    prog[1] = enc_r(5'd4, 5'd2, 5'd0, 5'd1);       dst[1] = 5'd2;  lit[1] = 16'd16;     sg[1] = 16'd0;
    prog[2] = enc_r(5'd0, 5'd3, 5'd0, 5'd0);       dst[2] = 5'd3;  lit[2] = 16'd0;      sg[2] = 16'd0;
    prog[3] = enc_i(5'd1, 5'd10, 5'd0, 16'hFFFF);  dst[3] = 5'd10; lit[3] = 16'hFFFF;   sg[3] = 16'd0;
    prog[4] = enc_i(5'd4, 5'd11, 5'd10, 16'hFFFF); dst[4] = 5'd11; lit[4] = 16'h0001;   sg[4] = 16'hFFFE;
    prog[5] = enc_r(5'd0, 5'd12, 5'd0, 5'd0);      dst[5] = 5'd12; lit[5] = 16'hFFFE;   sg[5] = 16'hFFFE;
    preset(16'd2);
    for (int i = 0; i < 6; i++) begin
      drive_instr(prog[i], wr);
      e = exp_q.pop_front();
      checks++;
      if (dut.GPR[dst[i]] !== e || dout !== lit[i]) begin
        errors++; $display("FAIL mul_step%0d: got gpr %h dout %h expected %h", i, dut.GPR[dst[i]], dout, lit[i]);
      end
      checks++;
      if (dut.SGPR !== sg[i]) begin
        errors++; $display("FAIL mul_step%0d_sgpr: got %h expected %h", i, dut.SGPR, sg[i]);
      end
    end
  endtask

  task automatic test_logic();
    bit wr;
    logic [15:0] e;
    logic [31:0] prog [5];
    logic [4:0]  dst  [5];
    logic [15:0] lit  [5];
    prog[0] = enc_i(5'd6,  5'd4, 5'd7, 16'd56); dst[0] = 5'd4; lit[0] = 16'd0;
    prog[1] = enc_i(5'd7,  5'd4, 5'd7, 16'd56); dst[1] = 5'd4; lit[1] = 16'd58;
    prog[2] = enc_r(5'd5,  5'd0, 5'd4, 5'd16);  dst[2] = 5'd0; lit[2] = 16'd58;
    prog[3] = enc_r(5'd10, 5'd0, 5'd4, 5'd16);  dst[3] = 5'd0; lit[3] = 16'hFFC5;
    prog[4] = enc_r(5'd11, 5'd1, 5'd6, 5'd9);   dst[4] = 5'd1; lit[4] = 16'hFFFD;
    preset(16'd2);
    for (int i = 0; i < 5; i++) begin
      drive_instr(prog[i], wr);
      e = exp_q.pop_front();
      checks++;
      if (dut.GPR[dst[i]] !== e || dout !== lit[i]) begin
        errors++; $display("FAIL logic_step%0d: got gpr %h dout %h expected %h", i, dut.GPR[dst[i]], dout, lit[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit wr;
    bit bad;
    preset(16'h1234);
    drive_instr(enc_i(5'd4, 5'd3, 5'd1, 16'h0100), wr);
    void'(exp_q.pop_front());
    dut.IR = enc_i(5'd2, 5'd5, 5'd5, 16'd1);
    #2;
    sys_rst = 1'b1;
    model_reset();
    #1;
    bad = 1'b0;
    for (int i = 0; i < 32; i++) if (dut.GPR[i] !== 16'd0) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL async_rst_gpr: got nonzero GPR expected all 0"); end
    checks++;
    if (dut.IR !== 32'd0 || dut.SGPR !== 16'd0 || dout !== 16'd0) begin
      errors++; $display("FAIL async_rst_state: got ir %h sgpr %h dout %h expected 0", dut.IR, dut.SGPR, dout);
    end
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    drive_instr(enc_i(5'd15, 5'd3, 5'd1, 16'd7), wr);
    bad = 1'b0;
    for (int i = 0; i < 32; i++) if (dut.GPR[i] !== 16'd0) bad = 1'b1;
    checks++;
    if (wr || bad || dout !== 16'd0 || dut.SGPR !== 16'd0) begin
      errors++; $display("FAIL noop_after_rst: got dout %h sgpr %h gpr_changed %0d expected 0", dout, dut.SGPR, bad);
    end
  endtask

  task automatic test_boundaries();
    bit wr;
    logic [15:0] e;
    logic [31:0] prog [6];
    logic [4:0]  dst  [6];
    logic [15:0] lit  [6];
    prog[0] = enc_i(5'd1, 5'd8, 5'd0, 16'hFFFF); dst[0] = 5'd8; lit[0] = 16'hFFFF;
    prog[1] = enc_i(5'd2, 5'd8, 5'd8, 16'd1);    dst[1] = 5'd8; lit[1] = 16'h0000;
    prog[2] = enc_i(5'd1, 5'd9, 5'd0, 16'd0);    dst[2] = 5'd9; lit[2] = 16'h0000;
    prog[3] = enc_i(5'd3, 5'd9, 5'd9, 16'd1);    dst[3] = 5'd9; lit[3] = 16'hFFFF;
    prog[4] = enc_i(5'd2, 5'd5, 5'd5, 16'd1);    dst[4] = 5'd5; lit[4] = 16'd3;
    prog[5] = enc_i(5'd2, 5'd5, 5'd5, 16'd1);    dst[5] = 5'd5; lit[5] = 16'd4;
    preset(16'd2);
    for (int i = 0; i < 6; i++) begin
      drive_instr(prog[i], wr);
      e = exp_q.pop_front();
      checks++;
      if (dut.GPR[dst[i]] !== e || dout !== lit[i]) begin
        errors++; $display("FAIL boundary_step%0d: got gpr %h dout %h expected %h", i, dut.GPR[dst[i]], dout, lit[i]);
      end
    end
  endtask

  task automatic test_random();
    bit wr;
    logic [15:0] e;
    logic [4:0]  op, rd;
    logic [31:0] instr;
    for (int i = 0; i < 32; i++) begin
      m_gpr[i]   = 16'($urandom_range(0, 65535));
      dut.GPR[i] = m_gpr[i];
    end
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(0, 15));
      rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        instr = enc_i(op, rd, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)));
      else
        instr = enc_r(op, rd, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      drive_instr(instr, wr);
      if (wr) begin
        e = exp_q.pop_front();
        checks++;
        if (dut.GPR[rd] !== e) begin
          errors++; $display("FAIL rand%0d_op%0d_gpr: got %h expected %h", n, op, dut.GPR[rd], e);
        end
      end
      checks++;
      if (dout !== m_dout || dut.SGPR !== m_sgpr) begin
        errors++; $display("FAIL rand%0d_op%0d_dout_sgpr: got %h/%h expected %h/%h", n, op, dout, dut.SGPR, m_dout, m_sgpr);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    din     = 16'hA5A5;
    sys_rst = 1'b1;
    test_reset();
    test_add_imm();
    test_mov();
    test_mul();
    test_logic();
    test_async_reset();
    test_boundaries();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
